// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg -- shared definitions for the divided-clock monitor.
//   DEF_CNT_W  : default width of the period / high-time counters
//   DEF_LOCK_N : default number of consecutive equal periods needed for lock
//   MATCH_W    : width of the lock match counter (LOCK_N is at most 15)
//   state_t    : measurement FSM states
// -----------------------------------------------------------------------------
package div_pkg;

   localparam int DEF_CNT_W  = 16;
   localparam int DEF_LOCK_N = 4;
   localparam int MATCH_W    = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

endpackage

// File: rtl/div_monitor_if.sv
// -----------------------------------------------------------------------------
// div_monitor_if -- control / result bundle of the divided-clock monitor.
//   en        : measurement enable (master -> slave)
//   sig_in    : monitored signal, asynchronous to clk (master -> slave)
//   period    : last measured period in clk cycles (slave -> master)
//   high_time : clk cycles the signal was high within that period
//   valid     : one-cycle pulse, period/high_time updated this cycle
//   locked    : LOCK_N consecutive equal periods seen
//   timeout   : sticky, counter saturated without a rising edge
// -----------------------------------------------------------------------------
interface div_monitor_if #(
   parameter int CNT_W = div_pkg::DEF_CNT_W
);

   logic             en;
   logic             sig_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             valid;
   logic             locked;
   logic             timeout;

   modport master (
      output en, sig_in,
      input  period, high_time, valid, locked, timeout
   );

   modport slave (
      input  en, sig_in,
      output period, high_time, valid, locked, timeout
   );

endinterface

// File: rtl/div_monitor_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge -- two-flop synchroniser plus delay flop and rising-edge detect.
//   clk  : sampling clock
//   rst  : asynchronous active-low reset
//   d    : asynchronous input
//   q    : synchronised input (second flop)
//   rise : one-cycle pulse when q goes 0 -> 1
// -----------------------------------------------------------------------------
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise
);

   logic s1_q, s2_q, s3_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking here would
   // collapse the three-stage chain into a single flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign q    = s2_q;
   assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/div_monitor.sv
// -----------------------------------------------------------------------------
// div_monitor -- measures period and high time of a divided clock, reports
// lock after LOCK_N consecutive equal periods and flags a stuck signal.
//   clk : sole clock, rising edge
//   rst : asynchronous active-low reset
//   bus : div_monitor_if slave (en, sig_in in; period, high_time, valid,
//         locked, timeout out)
// -----------------------------------------------------------------------------
module div_monitor
   import div_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int LOCK_N = DEF_LOCK_N
) (
   input logic          clk,
   input logic          rst,
   div_monitor_if.slave bus
);

   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
   localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
   localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_N);

   state_t             state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [CNT_W-1:0]   hcnt_q,   hcnt_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   high_q,   high_d;
   logic [MATCH_W-1:0] match_q,  match_d;
   logic               valid_q,  valid_d;
   logic               locked_q, locked_d;
   logic               timeout_q, timeout_d;

   logic s2;
   logic rise;

   sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.sig_in),
      .q    (s2),
      .rise (rise)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         match_q   <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         match_q   <= match_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      // NOTE: every next-state value gets a default before any branch, so
      // no path leaves a variable unassigned and no latch is inferred.
      state_d   = state_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      period_d  = period_q;
      high_d    = high_q;
      match_d   = match_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;

      if (!bus.en) begin
         // Disable dominates every state; results hold, status clears.
         state_d   = IDLE;
         cnt_d     = '0;
         hcnt_d    = '0;
         match_d   = '0;
         locked_d  = 1'b0;
         timeout_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = ARM;
               cnt_d   = '0;
               hcnt_d  = '0;
               match_d = '0;
            end

            ARM: begin
               // The first edge only starts a measurement; rise beats
               // saturation so a late edge still arms.
               if (rise) begin
                  state_d = MEASURE;
                  cnt_d   = CNT_ONE;
                  hcnt_d  = CNT_ONE;
               end else if (cnt_q == CNT_MAX) begin
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
                  match_d   = '0;
                  cnt_d     = '0;
                  hcnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end

            MEASURE: begin
               if (rise) begin
                  period_d  = cnt_q;
                  high_d    = hcnt_q;
                  valid_d   = 1'b1;
                  timeout_d = 1'b0;
                  cnt_d     = CNT_ONE;
                  hcnt_d    = CNT_ONE;
                  // match_q == 0 marks the first measurement since ARM, so
                  // period_q holds nothing comparable yet.
                  if (match_q == '0 || cnt_q != period_q) begin
                     match_d = MATCH_ONE;
                  end else if (match_q != MATCH_LOCK) begin
                     match_d = match_q + MATCH_ONE;
                  end
                  locked_d = (match_d == MATCH_LOCK);
               end else if (cnt_q == CNT_MAX) begin
                  state_d   = ARM;
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
                  match_d   = '0;
                  cnt_d     = '0;
                  hcnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
                  if (s2) begin
                     hcnt_d = hcnt_q + CNT_ONE;
                  end
               end
            end

            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.period    = period_q;
   assign bus.high_time = high_q;
   assign bus.valid     = valid_q;
   assign bus.locked    = locked_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_div_monitor.sv
// -----------------------------------------------------------------------------
// tb_div_monitor -- self-checking bench for div_monitor (CNT_W = 8).
// The reference model works on the cycle stamps of the rising edges the bench
// drives: a valid is due three cycles after each rise that closes a period of
// at most 2^CNT_W-1 cycles, carrying the gap and the driven high time.
// -----------------------------------------------------------------------------
module tb_div_monitor;
   import div_pkg::*;

   localparam int TB_CW  = 8;
   localparam int CMAX   = (1 << TB_CW) - 1;
   localparam int LOCKN  = 4;

   typedef struct {
      int cyc;
      int per;
      int hi;
      bit lock;
   } ev_t;

   logic clk;
   logic rst;

   div_monitor_if #(.CNT_W(TB_CW)) bus ();

   div_monitor #(
      .CNT_W  (TB_CW),
      .LOCK_N (LOCKN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int  vectors     = 0;
   int  miscompares = 0;
   int  cyc         = 0;

   // Reference model state
   ev_t exp_q[$];
   bit  m_armed = 1'b0;
   int  m_last  = 0;
   int  m_per   = 0;
   int  m_hi    = 0;
   int  m_match = 0;

   task automatic model_arm();
      m_armed = 1'b0;
      m_match = 0;
   endtask

   // A rise driven at stamp r closes the running period if one is open and
   // its length fits the counter; otherwise it only opens a new period.
   task automatic model_rise(input int r);
      ev_t e;
      if (m_armed && (r - m_last) <= CMAX) begin
         e.cyc = r + 3;
         e.per = r - m_last;
         e.hi  = m_hi;
         if (m_match == 0 || e.per != m_per) m_match = 1;
         else if (m_match < LOCKN)           m_match = m_match + 1;
         m_per  = e.per;
         e.lock = (m_match == LOCKN);
         exp_q.push_back(e);
      end else if (m_armed) begin
         m_match = 0;
      end
      m_armed = 1'b1;
      m_last  = r;
   endtask

   task automatic drive_wave(input int per, input int hi, input int n);
      for (int p = 0; p < n; p++) begin
         for (int i = 0; i < per; i++) begin
            @(negedge clk);
            if (i == 0) begin
               model_rise(cyc);
               m_hi = hi;
            end
            bus.sig_in = (i < hi);
         end
      end
   endtask

   task automatic idle_low(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.sig_in = 1'b0;
      end
   endtask

   // Monitor / scoreboard: every valid must match the next expected event.
   initial begin
      ev_t e;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1;
         if (bus.valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_valid: cyc=%0d period=%0d high=%0d, no valid was due",
                        cyc, bus.period, bus.high_time);
            end else begin
               e = exp_q.pop_front();
               if (cyc != e.cyc || bus.period !== TB_CW'(e.per) ||
                   bus.high_time !== TB_CW'(e.hi) || bus.locked !== e.lock ||
                   bus.timeout !== 1'b0) begin
                  miscompares++;
                  $display("FAIL valid_event: got cyc=%0d period=%0d high=%0d locked=%b timeout=%b, expected cyc=%0d period=%0d high=%0d locked=%b timeout=0",
                           cyc, bus.period, bus.high_time, bus.locked, bus.timeout,
                           e.cyc, e.per, e.hi, e.lock);
               end
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missed_valid: no valid at cyc=%0d, expected period=%0d high=%0d",
                     cyc, exp_q[0].per, exp_q[0].hi);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d",
               vectors, miscompares);
      $fatal(1, "watchdog expired");
   end

   task automatic test_reset();
      rst        = 1'b0;
      bus.en     = 1'b0;
      bus.sig_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({bus.period, bus.high_time, bus.valid, bus.locked, bus.timeout} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: period=%h high=%h valid=%b locked=%b timeout=%b, expected all 0",
                  bus.period, bus.high_time, bus.valid, bus.locked, bus.timeout);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      bus.en = 1'b1;
      model_arm();
      idle_low(3);
   endtask

   task automatic test_div4();
      drive_wave(4, 2, 4);
      vectors++;
      if (bus.locked !== 1'b0) begin
         miscompares++;
         $display("FAIL div4_unlocked_after_3: locked=%b expected 0", bus.locked);
      end
      drive_wave(4, 2, 1);
      vectors++;
      if (bus.locked !== 1'b1 || bus.period !== 8'd4 || bus.high_time !== 8'd2) begin
         miscompares++;
         $display("FAIL div4_lock_on_4th: locked=%b period=%0d high=%0d, expected 1/4/2",
                  bus.locked, bus.period, bus.high_time);
      end
      drive_wave(4, 2, 1);
   endtask

   task automatic test_lock_switch();
      drive_wave(10, 3, 6);
      vectors++;
      if (bus.locked !== 1'b1 || bus.period !== 8'd10 || bus.high_time !== 8'd3) begin
         miscompares++;
         $display("FAIL p10_locked: locked=%b period=%0d high=%0d, expected 1/10/3",
                  bus.locked, bus.period, bus.high_time);
      end
      drive_wave(12, 5, 2);
      vectors++;
      if (bus.locked !== 1'b0 || bus.period !== 8'd12) begin
         miscompares++;
         $display("FAIL p12_lock_drop: locked=%b period=%0d, expected 0/12",
                  bus.locked, bus.period);
      end
      drive_wave(12, 5, 3);
      vectors++;
      if (bus.locked !== 1'b1) begin
         miscompares++;
         $display("FAIL p12_relock: locked=%b expected 1", bus.locked);
      end
   endtask

   task automatic test_edge_timing();
      int rc;
      drive_wave(8, 4, 2);
      @(negedge clk);
      rc = cyc;
      model_rise(rc);
      m_hi = 3;
      bus.sig_in = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (bus.valid !== (k == 3)) begin
            miscompares++;
            $display("FAIL edge_latency: valid=%b at edge +%0d, expected %b",
                     bus.valid, k, (k == 3));
         end
      end
      @(negedge clk);
      bus.sig_in = 1'b0;
      idle_low(4);
      drive_wave(8, 4, 2);
   endtask

   task automatic test_en_drop();
      drive_wave(6, 3, 6);
      @(negedge clk);
      bus.en = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (bus.locked !== 1'b0 || bus.timeout !== 1'b0 || bus.valid !== 1'b0 ||
          bus.period !== 8'd6 || bus.high_time !== 8'd3) begin
         miscompares++;
         $display("FAIL en_drop: locked=%b timeout=%b valid=%b period=%0d high=%0d, expected 0/0/0/6/3",
                  bus.locked, bus.timeout, bus.valid, bus.period, bus.high_time);
      end
      idle_low(4);
      @(negedge clk);
      bus.en = 1'b1;
      model_arm();
      idle_low(3);
      drive_wave(6, 3, 2);
      vectors++;
      if (bus.locked !== 1'b0) begin
         miscompares++;
         $display("FAIL en_reenable_unlocked: locked=%b expected 0", bus.locked);
      end
      drive_wave(6, 3, 1);
   endtask

   task automatic test_reset_mid();
      drive_wave(6, 3, 5);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if ({bus.period, bus.high_time, bus.valid, bus.locked, bus.timeout} !== '0) begin
         miscompares++;
         $display("FAIL reset_async: period=%h high=%h valid=%b locked=%b timeout=%b, expected all 0",
                  bus.period, bus.high_time, bus.valid, bus.locked, bus.timeout);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_arm();
      idle_low(3);
      drive_wave(6, 3, 3);
   endtask

   task automatic test_timeout();
      int rs;
      drive_wave(8, 4, 6);
      @(negedge clk);
      rs = cyc;
      model_rise(rs);
      m_hi = 2;
      bus.sig_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.sig_in = 1'b0;
      while (cyc < rs + 3 + CMAX - 1) @(negedge clk);
      vectors++;
      if (bus.timeout !== 1'b0 || bus.locked !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_early: timeout=%b locked=%b one cycle before saturation, expected 0/1",
                  bus.timeout, bus.locked);
      end
      @(negedge clk);
      vectors++;
      if (bus.timeout !== 1'b1 || bus.locked !== 1'b0 || dut.state_q !== ARM ||
          bus.period !== 8'd8) begin
         miscompares++;
         $display("FAIL timeout_set: timeout=%b locked=%b state=%0d period=%0d, expected 1/0/ARM/8",
                  bus.timeout, bus.locked, dut.state_q, bus.period);
      end
   endtask

   task automatic test_rise_wins();
      drive_wave(8, 4, 1);
      vectors++;
      if (bus.timeout !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_sticky: timeout=%b expected 1", bus.timeout);
      end
      drive_wave(8, 4, 2);
      vectors++;
      if (bus.timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_clear_on_valid: timeout=%b expected 0", bus.timeout);
      end
      drive_wave(255, 100, 1);
      drive_wave(256, 100, 1);
      drive_wave(8, 4, 1);
      vectors++;
      if (bus.period !== 8'd255 || bus.high_time !== 8'd100 || bus.timeout !== 1'b1) begin
         miscompares++;
         $display("FAIL saturation_boundary: period=%0d high=%0d timeout=%b, expected 255/100/1",
                  bus.period, bus.high_time, bus.timeout);
      end
      drive_wave(8, 4, 3);
   endtask

   task automatic test_random();
      int per, hi, n;
      repeat (12) begin
         per = $urandom_range(40, 4);
         hi  = $urandom_range(per - 1, 1);
         n   = $urandom_range(5, 1);
         drive_wave(per, hi, n);
         idle_low($urandom_range(3, 0));
      end
      drive_wave(8, 4, 2);
      idle_low(6);
   endtask

   initial begin
      test_reset();
      test_div4();
      test_lock_switch();
      test_edge_timing();
      test_en_drop();
      test_reset_mid();
      test_timeout();
      test_rise_wins();
      test_random();
      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/div_monitor.md
DIV_MONITOR -- requirements
Module: div_monitor

Interface
REQ-001 Parameter CNT_W, default 16, width of period and high-time counters.
REQ-002 Parameter LOCK_N, default 4, number of consecutive equal periods required for lock (2..15).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  measurement enable; low forces IDLE.
REQ-006 sig_in  input  1  monitored divided-clock signal, asynchronous to clk.
REQ-007 period  output  CNT_W  last measured period, in clk cycles, rising edge to rising edge.
REQ-008 high_time  output  CNT_W  clk cycles that the synchronised sig_in was high within the last period.
REQ-009 valid  output  1  one-cycle pulse; period and high_time were updated this cycle.
REQ-010 locked  output  1  LOCK_N consecutive equal periods have been measured.
REQ-011 timeout  output  1  sticky; the counter saturated with no rising edge; cleared by the next valid or by en low.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchroniser (s1, s2) plus a delay flop s3; rise = s2 & ~s3.
REQ-013 The FSM SHALL have three states: IDLE, ARM, and MEASURE.
REQ-014 IDLE: en=1 -> ARM next cycle; cnt, hcnt, match_cnt = 0.
REQ-015 ARM: rise -> MEASURE, cnt=1, hcnt=1; no valid is issued for this first edge.
REQ-016 MEASURE, no rise: cnt += 1; hcnt += 1 when s2=1.
REQ-017 MEASURE, rise: period <= cnt, high_time <= hcnt, valid=1, cnt <= 1, hcnt <= 1, all in the same cycle.
REQ-018 Latency: a sig_in rising edge that is stable before clk edge k produces rise in cycle k+2 and valid in cycle k+3.
REQ-019 Saturation: when cnt reaches 2^CNT_W-1 in MEASURE or ARM, the block SHALL set timeout, clear locked, clear match_cnt, and go to ARM; period and high_time hold.
REQ-020 Lock: on each valid, if the new period equals the previous period then match_cnt += 1 (saturating at LOCK_N); otherwise match_cnt = 1.
REQ-021 Lock threshold: locked SHALL equal (match_cnt == LOCK_N) and update in the same cycle as valid.
REQ-022 The first valid after ARM SHALL set match_cnt = 1, because there is no previous period.
REQ-023 en deasserted in any state SHALL force IDLE next cycle, clear locked, timeout, and match_cnt, and produce no valid; period and high_time hold.
REQ-024 If rise and saturation occur in the same cycle, rise SHALL win: the measurement completes with period = 2^CNT_W-1 and timeout is not set.
REQ-025 A sig_in that is constantly high or constantly low SHALL produce no valid and SHALL produce timeout after 2^CNT_W-1 cycles.

Reset
REQ-026 While rst=0, the block SHALL set state = IDLE and set s1, s2, s3, cnt, hcnt, match_cnt, period, high_time, valid, locked, and timeout all to 0, asynchronously.
REQ-027 Reset deassertion SHALL take effect at the next clk edge; the first measurement always passes through ARM.
REQ-028 Reset asserted mid-measurement SHALL discard the partial count with no valid.

Structure
REQ-029 A shared package div_pkg SHALL hold the FSM state enum (IDLE, ARM, MEASURE) and the default CNT_W and LOCK_N constants.
REQ-030 The synchroniser plus edge detector SHALL be one sub-module, sync_edge (ports clk, rst, d, q, rise).
REQ-031 All other logic SHALL stay in div_monitor; there are no other sub-modules.

Verification
REQ-032 Directed: sig_in = divide-by-4 output of the team divider (pattern 1,0,0,1) -> every valid gives period=4 and high_time=2; locked rises on the 4th valid.
REQ-033 Directed: period 10, high 3, then switch to period 12 -> valid shows 12, locked drops that cycle and returns after 4 valids of 12.
REQ-034 Directed: CNT_W=8, sig_in held low after one edge -> timeout=1 after 255 cycles, state ARM, locked=0.
REQ-035 Directed: en dropped during MEASURE at period 6 -> no valid, locked=0 next cycle; re-enable -> first valid after ARM plus one full period.
REQ-036 Directed: rst pulsed low mid-period -> all outputs 0 asynchronously; resume -> first valid is one full period after the first post-reset rise.
REQ-037 Directed: edge timing -> a sig_in rise before clk edge k yields valid exactly at cycle k+3.
